data_mem_ctrl: RTL
==================

# data_mem_ctrl

Data-memory responder for the RISC-V core: accepts load/store requests carrying the datapath's ALU result as address and register rs2 as write data, and returns load data for the writeback mux. It performs byte/halfword/word accesses per funct3, sign- or zero-extends loads, flags misaligned or illegal accesses, and inserts a configurable number of wait states so the core's multi-cycle control can be exercised against non-ideal memory.

## Interface

- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥ 4.
- WAIT_CYCLES, 1: wait states between acceptance and access, 0–15.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  access size/sign, RISC-V encoding.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  load result, valid only while ready = 1.
- ready  out  1  one-cycle response pulse.
- err  out  1  valid with ready: misaligned or illegal funct3.

## Operation

- Storage: DEPTH_WORDS × 32-bit array, little-endian. Word index = addr[log2(DEPTH_WORDS)+1:2]; upper address bits ignored, so addresses wrap modulo 4·DEPTH_WORDS bytes. Contents not cleared by rst.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on req = 1, register we, funct3, addr, wdata; load the wait counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES > 0, else to RESP.
  - WAIT: decrement the counter each cycle. Go to RESP in the cycle the counter reads 1.
  - RESP: perform the access on the registered request. Drive ready = 1 for exactly this cycle, then go to IDLE.
- Inputs are ignored outside IDLE; the requester holds nothing after acceptance.
- Loads:
  - 000 LB: sign-extend byte addr[1:0].
  - 001 LH: sign-extend halfword addr[1].
  - 010 LW: full word.
  - 100 LBU and 101 LHU: zero-extend.
- Stores write only the addressed lanes; other bytes are unchanged.
  - 000 SB: wdata[7:0].
  - 001 SH: wdata[15:0].
  - 010 SW: full word.
- Error conditions:
  - Illegal: load funct3 ∈ {011, 110, 111}; store funct3 ∉ {000, 001, 010}.
  - Misaligned: halfword with addr[0] = 1; word with addr[1:0] ≠ 00.
  - On error, memory is not modified, rdata = 0, and err = 1 with ready.
- rdata = 0 and err = 0 whenever ready = 0.
- A store response has ready = 1 and rdata = 0.

## Timing

- Reset values: ready = 0, err = 0, rdata = 0, state = IDLE, counter = 0.
- Latency: req accepted at edge N gives ready high in cycle N+1+WAIT_CYCLES.
- Store commit: the memory write occurs at the edge ending the RESP cycle. A load issued afterwards sees the new data.
- Throughput: one transaction per WAIT_CYCLES+2 cycles. A req asserted during RESP is ignored; the requester re-asserts it in IDLE.
- Reset mid-operation (WAIT or RESP): the transaction is aborted, no memory write occurs, ready is not pulsed, and the FSM returns to IDLE on the next cycle.
- rst = 1 together with req = 1: rst wins; the request is not accepted.
- Read data is combinational from the array, registered into rdata at entry to RESP.

## Test plan

- Reset: hold rst 2 cycles with req = 1 → ready, err, and rdata stay 0; no memory change.
- Word round-trip, WAIT_CYCLES = 1: SW 0xDEADBEEF @0x10, then LW @0x10 → each ready lands 2 cycles after acceptance; LW rdata = 0xDEADBEEF, err = 0.
- Sub-word:
  - SB 0x80 @0x13 over 0x00000000 → word = 0x80000000.
  - LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080.
  - SH 0x8001 @0x12 → LH @0x12 = 0xFFFF8001, LHU = 0x00008001.
- Errors:
  - LW @0x11 → ready with err = 1, rdata = 0.
  - SH @0x21 → err = 1; LW @0x20 shows the old value.
  - Load funct3 = 011 → err = 1.
- Wrap and back-to-back, DEPTH_WORDS = 1024: SW 0x12345678 @0x1000 → LW @0x0 returns 0x12345678. Pulsing req every cycle → exactly one ready per WAIT_CYCLES+2 cycles; requests during RESP are dropped.
- Reset mid-WAIT, WAIT_CYCLES = 4: issue SW 0xAAAAAAAA @0x40 and assert rst 2 cycles after acceptance → no ready pulse; LW @0x40 returns the prior value.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the RISC-V core: byte/half/word loads and stores
// with sign/zero extension, error flagging and a configurable number of wait states.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [1:0]  fsm_state
);
    // Handshake: req is sampled only in IDLE; ready is a one-cycle pulse in RESP,
    // and rdata/err are meaningful only while ready = 1 (both are 0 otherwise).
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state, state_next;
    logic [3:0]    cnt;
    logic          q_we;
    logic [2:0]    q_funct3;
    logic [AW+1:0] q_addr;
    logic [31:0]   q_wdata;

    logic          acc_we;
    logic [2:0]    acc_funct3;
    logic [AW+1:0] acc_addr;
    logic          acc_err;
    logic          illegal;
    logic          misaligned;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [31:0]   load_val;
    logic [31:0]   lane_mask;
    logic [31:0]   lane_data;
    logic [31:0]   store_word;
    logic          addr_unused;

    assign addr_unused = ^addr[31:AW+2];
    assign ready       = (state == ST_RESP);
    assign fsm_state   = state;

    // With zero wait states RESP is entered on the accepting edge, so the
    // access is evaluated on the live inputs while in IDLE.
    always_comb begin
        acc_we     = q_we;
        acc_funct3 = q_funct3;
        acc_addr   = q_addr;
        if (state == ST_IDLE) begin
            acc_we     = we;
            acc_funct3 = funct3;
            acc_addr   = addr[AW+1:0];
        end
    end

    always_comb begin
        illegal = 1'b0;
        if (acc_we)
            illegal = (acc_funct3 > 3'b010);
        else
            illegal = (acc_funct3 == 3'b011) || (acc_funct3 == 3'b110) || (acc_funct3 == 3'b111);
        misaligned = ((acc_funct3[1:0] == 2'b01) && acc_addr[0]) ||
                     ((acc_funct3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
        acc_err = illegal || misaligned;
    end

    always_comb begin
        idx      = acc_addr[AW+1:2];
        word     = mem[idx];
        sel_byte = word[{acc_addr[1:0], 3'b000} +: 8];
        sel_half = acc_addr[1] ? word[31:16] : word[15:0];
        case (acc_funct3)
            3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
            3'b010:  load_val = word;
            3'b100:  load_val = {24'd0, sel_byte};
            3'b101:  load_val = {16'd0, sel_half};
            default: load_val = 32'd0;
        endcase
    end

    // Read-modify-write merge; only used in RESP, where idx comes from q_addr.
    always_comb begin
        case (q_funct3[1:0])
            2'b00:   lane_mask = 32'h0000_00FF << {q_addr[1:0], 3'b000};
            2'b01:   lane_mask = 32'h0000_FFFF << {q_addr[1:0], 3'b000};
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
        lane_data  = q_wdata << {q_addr[1:0], 3'b000};
        store_word = (word & ~lane_mask) | (lane_data & lane_mask);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req) state_next = (WAIT_INIT == 4'd0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt <= 4'd1) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            rdata    <= 32'd0;
            err      <= 1'b0;
            q_we     <= 1'b0;
            q_funct3 <= 3'd0;
            q_addr   <= '0;
            q_wdata  <= 32'd0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && req) begin
                q_we     <= we;
                q_funct3 <= funct3;
                q_addr   <= addr[AW+1:0];
                q_wdata  <= wdata;
                cnt      <= WAIT_INIT;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (state_next == ST_RESP) begin
                err   <= acc_err;
                rdata <= (acc_we || acc_err) ? 32'd0 : load_val;
            end else begin
                err   <= 1'b0;
                rdata <= 32'd0;
            end
        end
    end

    // Storage is never reset; a store commits on the edge that ends RESP.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_RESP && q_we && !err)
            mem[idx] <= store_word;
    end
endmodule
